// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Optional frame statistics counter enabled by defining UART_ARB_STATS_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 14
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [8*NUM_REQ-1:0]   DataBus,
  output logic [NUM_REQ-1:0]     Grant,
  output logic                   TxEnable,
  output logic [7:0]             TxData,
  output logic                   Busy
`ifdef UART_ARB_STATS_EN
  ,
  output logic [15:0]            FrameCount
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      scan_idx;

  // Scan from the requester just after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && Req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    en_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = SEND;
          grant_d[win_idx] = 1'b1;
          en_d             = 1'b1;
          data_d           = DataBus[win_idx*8 +: 8];
          ptr_d            = win_idx;
        end
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = 8'(FRAME_CYCLES - 1);
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      grant_q <= '0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign Grant    = grant_q;
  assign TxEnable = en_q;
  assign TxData   = data_q;
  assign Busy     = busy_q;

`ifdef UART_ARB_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts SEND cycles; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == SEND) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign FrameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a remaining-cycles transaction model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int FC = 14;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [8*N-1:0] DataBus;
  logic [N-1:0]   Grant;
  logic           TxEnable;
  logic [7:0]     TxData;
  logic           Busy;
`ifdef UART_ARB_STATS_EN
  logic [15:0]    FrameCount;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(FC)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .DataBus(DataBus),
    .Grant(Grant), .TxEnable(TxEnable), .TxData(TxData), .Busy(Busy)
`ifdef UART_ARB_STATS_EN
    , .FrameCount(FrameCount)
`endif
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles left before arbitration is allowed again.
  int           m_left;
  int           m_ptr;
  logic [N-1:0] m_grant;
  logic         m_en;
  logic [7:0]   m_data;
  int           m_frames;

  always @(posedge Clock) begin
    if (Reset) begin
      m_left = 0; m_ptr = N - 1; m_grant = '0; m_en = 1'b0; m_data = 8'h00; m_frames = 0;
    end else begin
      if (m_en) m_frames = m_frames + 1;
      m_grant = '0;
      m_en    = 1'b0;
      if (m_left > 0) m_left = m_left - 1;
      else if (Req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (m_en == 1'b0 && Req[idx]) begin
            m_en = 1'b1;
            m_grant[idx] = 1'b1;
            m_data = DataBus[idx*8 +: 8];
            m_ptr = idx;
            m_left = FC + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
    chk("grant",  32'(Grant),    32'(m_grant));
    chk("txen",   32'(TxEnable), 32'(m_en));
    chk("txdata", 32'(TxData),   32'(m_data));
    chk("busy",   32'(Busy),     32'(m_left > 0));
`ifdef UART_ARB_STATS_EN
    chk("framecount", 32'(FrameCount), 32'(m_frames & 16'hFFFF));
`endif
  endtask

  task automatic wait_pulse(input string tag, output logic [N-1:0] g, output logic [7:0] d,
                            output int ncyc);
    logic got;
    got = 1'b0; g = '0; d = 8'h00; ncyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc();
      ncyc++;
      if (TxEnable) begin got = 1'b1; g = Grant; d = TxData; end
    end
    if (!got) begin
      tests++; fails++;
      $error("FAIL %s timeout observed=no_pulse expected=pulse", tag);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Req = '0;
    cyc();
    Reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [7:0]   d;
    int           nc, n_busy, n_en;
    logic [7:0]   exp_seq [5];
    logic [N-1:0] exp_gnt [5];

    Reset = 1'b1; Req = '0; DataBus = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_txen", 32'(TxEnable), 32'd0);
    chk("rst_data", 32'(TxData), 32'h00);
    chk("rst_grant", 32'(Grant), 32'd0);
    Reset = 1'b0;
    cyc();

    // Single requester, one-cycle latency, 15 busy cycles.
    Req = 4'b0001; DataBus[7:0] = 8'hA5;
    cyc();
    chk("t1_grant", 32'(Grant), 32'b0001);
    chk("t1_data", 32'(TxData), 32'hA5);
    Req = '0; n_busy = 1;
    for (int i = 0; i < 30; i++) begin cyc(); if (Busy) n_busy++; end
    chk("t1_busy_len", 32'(n_busy), 32'd15);

    // All requesting: rotation 0,1,2,3,0 with a 16-cycle period.
    do_reset();
    DataBus = {8'h43, 8'h32, 8'h21, 8'h10}; Req = 4'b1111;
    exp_seq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int p = 0; p < 5; p++) begin
      wait_pulse("t2_pulse", g, d, nc);
      chk("t2_data", 32'(d), 32'(exp_seq[p]));
      chk("t2_grant", 32'(g), 32'(exp_gnt[p]));
      if (p > 0) chk("t2_period", 32'(nc), 32'd16);
    end

    // Wrap past index 3 back to 0, then 2.
    do_reset();
    Req = 4'b0100;
    wait_pulse("t3_first", g, d, nc);
    chk("t3_first", 32'(g), 32'b0100);
    Req = 4'b0101;
    wait_pulse("t3_second", g, d, nc);
    chk("t3_second", 32'(g), 32'b0001);
    wait_pulse("t3_third", g, d, nc);
    chk("t3_third", 32'(g), 32'b0100);

    // Byte sampled only at grant; Req pulsed only during WAIT earns nothing.
    do_reset();
    DataBus[15:8] = 8'h5C; Req = 4'b0010;
    cyc();
    chk("t4_grant", 32'(Grant), 32'b0010);
    Req = '0;
    cyc();
    DataBus[15:8] = 8'hE7;
    cyc();
    Req = 4'b1000;
    cyc(); cyc(); cyc();
    Req = '0;
    chk("t4_hold", 32'(TxData), 32'h5C);
    n_en = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (TxEnable) n_en++; end
    chk("t4_no_grant", 32'(n_en), 32'd0);
    chk("t4_hold_end", 32'(TxData), 32'h5C);

    // Reset during the 5th WAIT cycle.
    do_reset();
    Req = 4'b0001;
    cyc();
    Req = '0;
    for (int i = 0; i < 5; i++) cyc();
    chk("t5_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b1;
    cyc();
    chk("t5_busy", 32'(Busy), 32'd0);
    chk("t5_txen", 32'(TxEnable), 32'd0);
    Reset = 1'b0; Req = 4'b1000;
    cyc();
    chk("t5_grant3", 32'(Grant), 32'b1000);
    Req = 4'b1001;
    wait_pulse("t5_next", g, d, nc);
    chk("t5_grant0", 32'(g), 32'b0001);

`ifdef UART_ARB_STATS_EN
    do_reset();
    Req = 4'b0111;
    for (int p = 0; p < 3; p++) wait_pulse("st_pulse", g, d, nc);
    Req = '0;
    cyc();
    chk("st_count3", 32'(FrameCount), 32'd3);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      Reset   = ($urandom_range(0, 60) == 0);
      Req     = N'($urandom);
      DataBus = {$urandom, $urandom};
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
